// File: rtl/instr_issue_unit.sv
// Instruction-side initiator: program memory, PC and instruction issue.
// Presents one instruction at a time and holds it for the CPU control FSM.
module instr_issue_unit #(
   parameter int          DEPTH       = 64,
   parameter int          AW          = 6,
   parameter int          HOLD_CYCLES = 4,
   parameter logic [31:0] HALT_WORD   = 32'hFFFFFFFF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data,
   input  logic          start,
   input  logic          stall,
   output logic [31:0]   instrword,
   output logic          newinstr,
   output logic [31:0]   pc,
   output logic          busy,
   output logic          done
);

   localparam int CW = $clog2(HOLD_CYCLES + 1);
   localparam logic [31:0] LAST_PC = 32'((DEPTH - 1) * 4);
   localparam logic [CW-1:0] CNT_INIT = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      HOLD,
      HALTED
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [31:0]   mem [DEPTH];
   logic [31:0]   word;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic [31:0]   instr_n;
   logic [31:0]   pc_n;
   logic          new_n;
   logic          busy_n;
   logic          done_n;
   logic          idle_like;

   assign idle_like = (state == IDLE) || (state == HALTED);
   assign word = mem[pc[AW+1:2]];

   // Program load; contents are kept across reset.
   always_ff @(posedge clk) begin
      if (load_en && idle_like) begin
         mem[load_addr] <= load_data;
      end
   end

   // State and issue registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         instrword <= '0;
         newinstr  <= 1'b0;
         pc        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cnt       <= '0;
      end else begin
         state     <= state_n;
         instrword <= instr_n;
         newinstr  <= new_n;
         pc        <= pc_n;
         busy      <= busy_n;
         done      <= done_n;
         cnt       <= cnt_n;
      end
   end

   // Next-state and next-output decision.
   always_comb begin
      state_n = state;
      instr_n = instrword;
      new_n   = 1'b0;
      pc_n    = pc;
      busy_n  = busy;
      done_n  = done;
      cnt_n   = cnt;
      unique case (state)
         IDLE, HALTED: begin
            if (start) begin
               pc_n    = '0;
               done_n  = 1'b0;
               busy_n  = 1'b1;
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            if (word == HALT_WORD) begin
               state_n = HALTED;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end else begin
               instr_n = word;
               new_n   = 1'b1;
               cnt_n   = CNT_INIT;
               state_n = HOLD;
            end
         end
         HOLD: begin
            if (!stall) begin
               if (cnt > CNT_ONE) begin
                  cnt_n = cnt - CNT_ONE;
               end else begin
                  pc_n = pc + 32'd4;
                  if (pc == LAST_PC) begin
                     state_n = HALTED;
                     busy_n  = 1'b0;
                     done_n  = 1'b1;
                  end else begin
                     state_n = ISSUE;
                  end
               end
            end
         end
      endcase
   end

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed bench for instr_issue_unit.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_instr_issue_unit;

   localparam logic [31:0] HALT = 32'hFFFFFFFF;
   localparam logic [31:0] I0 = 32'h00432020;
   localparam logic [31:0] I1 = 32'h8C250004;
   localparam logic [31:0] I2 = 32'hAC250008;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_en = 1'b0;
   logic [5:0]  load_addr = '0;
   logic [31:0] load_data = '0;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic [31:0] instrword;
   logic        newinstr;
   logic [31:0] pc;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail = 0;

   instr_issue_unit dut (
      .clk       (clk),
      .rst       (rst),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .start     (start),
      .stall     (stall),
      .instrword (instrword),
      .newinstr  (newinstr),
      .pc        (pc),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_instr"}, instrword, 32'h0);
      check_eq({tag, "_new"}, 32'(newinstr), 32'h0);
      check_eq({tag, "_pc"}, pc, 32'h0);
      check_eq({tag, "_busy"}, 32'(busy), 32'h0);
      check_eq({tag, "_done"}, 32'(done), 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic load(input logic [5:0] a, input logic [31:0] d);
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic load_prog();
      load(6'd0, I0);
      load(6'd1, I1);
      load(6'd2, I2);
      load(6'd3, HALT);
   endtask

   // Returns at the negedge after the edge that sampled start.
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits for the next newinstr and checks its spacing and contents.
   task automatic expect_pulse(input string tag, input int gap,
                               input logic [31:0] ins,
                               input logic [31:0] p);
      int  cyc;
      logic seen;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (newinstr) seen = 1'b1;
      end
      check_eq({tag, "_gap"}, seen ? 32'(cyc) : 32'h0, 32'(gap));
      check_eq({tag, "_instr"}, instrword, ins);
      check_eq({tag, "_pc"}, pc, p);
   endtask

   task automatic expect_done(input string tag, input int gap,
                              input logic [31:0] p);
      int cyc;
      cyc = 0;
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check_eq({tag, "_gap"}, done ? 32'(cyc) : 32'h0, 32'(gap));
      check_eq({tag, "_busy"}, 32'(busy), 32'h0);
      check_eq({tag, "_pc"}, pc, p);
   endtask

   initial begin
      int pulses;
      int cyc;
      logic [31:0] last;

      // Power-up reset.
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_zero("rst0");

      // Basic run.
      load_prog();
      pulse_start();
      check_eq("t2_busy", 32'(busy), 32'h1);
      check_eq("t2_new0", 32'(newinstr), 32'h0);
      expect_pulse("t2_p0", 1, I0, 32'd0);
      expect_pulse("t2_p1", 4, I1, 32'd4);
      expect_pulse("t2_p2", 4, I2, 32'd8);
      expect_done("t2_done", 4, 32'd12);
      check_eq("t2_keep", instrword, I2);

      // Reset out of HALTED.
      do_reset();
      check_zero("rst_h");

      // Stall during the first hold.
      pulse_start();
      expect_pulse("t3_p0", 1, I0, 32'd0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("t3_stall_instr", instrword, I0);
         check_eq("t3_stall_new", 32'(newinstr), 32'h0);
      end
      stall = 1'b0;
      expect_pulse("t3_p1", 4, I1, 32'd4);
      expect_pulse("t3_p2", 4, I2, 32'd8);
      expect_done("t3_done", 4, 32'd12);

      // Full memory, no halt word.
      for (int i = 0; i < 64; i++) begin
         load(6'(i), 32'h20000000 | 32'(i));
      end
      pulse_start();
      pulses = 0;
      cyc = 0;
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (newinstr) pulses++;
      end
      check_eq("t4_pulses", 32'(pulses), 32'd64);
      check_eq("t4_done", 32'(done), 32'h1);
      check_eq("t4_pc", pc, 32'd256);
      check_eq("t4_last", instrword, 32'h2000003F);
      check_eq("t4_cycles", 32'(cyc), 32'd256);

      // Load and start while busy are ignored.
      load_prog();
      pulse_start();
      expect_pulse("t5_p0", 1, I0, 32'd0);
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = 6'd1;
      load_data = 32'hDEADBEEF;
      start     = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
      start   = 1'b0;
      check_eq("t5_pc_hold", pc, 32'd0);
      expect_pulse("t5_p1", 2, I1, 32'd4);
      expect_pulse("t5_p2", 4, I2, 32'd8);
      expect_done("t5_done", 4, 32'd12);

      // Reset mid-hold of instruction 1, then rerun.
      pulse_start();
      expect_pulse("t6_p0", 1, I0, 32'd0);
      expect_pulse("t6_p1", 4, I1, 32'd4);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_zero("t6_rst");
      last = instrword;
      @(negedge clk);
      check_eq("t6_idle_new", 32'(newinstr), 32'h0);
      check_eq("t6_idle_instr", instrword, last);
      pulse_start();
      expect_pulse("t6_r0", 1, I0, 32'd0);
      expect_pulse("t6_r1", 4, I1, 32'd4);
      expect_pulse("t6_r2", 4, I2, 32'd8);
      expect_done("t6_done", 4, 32'd12);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
